// File: rtl/sinfonia_pkg.sv
// Shared types and constants for the note playback sequencer.
package sinfonia_pkg;

  localparam int unsigned NOTA_W    = 7;
  localparam int unsigned ARDUINO_W = 3;

  localparam logic [ARDUINO_W-1:0] SILENCIO = 3'd0;

  typedef enum logic [2:0] {
    OCIOSO,
    LE_MEMORIA,
    TOCA,
    PAUSA,
    FIM
  } estado_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sequenciador_reproducao_if.sv
// Control/memory/output bundle of the playback sequencer.
// The i_repetir signal exists only when SEQ_REPETE_EN is defined.
interface sequenciador_reproducao_if #(
  parameter int unsigned ADDR_W = 4
) ();
  import sinfonia_pkg::*;

  logic                 i_iniciar;
  logic                 i_abortar;
  logic                 i_nivel;
  logic [ADDR_W-1:0]    i_limite;
  logic [NOTA_W-1:0]    i_memoria_dado;
`ifdef SEQ_REPETE_EN
  logic                 i_repetir;
`endif
  logic [ADDR_W-1:0]    o_memoria_endereco;
  logic [NOTA_W-1:0]    o_leds;
  logic [ARDUINO_W-1:0] o_arduino_out;
  logic                 o_ativo;
  logic                 o_pronto;

`ifdef SEQ_REPETE_EN
  modport master (
    output i_iniciar, i_abortar, i_nivel, i_limite, i_memoria_dado, i_repetir,
    input  o_memoria_endereco, o_leds, o_arduino_out, o_ativo, o_pronto
  );
  modport slave (
    input  i_iniciar, i_abortar, i_nivel, i_limite, i_memoria_dado, i_repetir,
    output o_memoria_endereco, o_leds, o_arduino_out, o_ativo, o_pronto
  );
`else
  modport master (
    output i_iniciar, i_abortar, i_nivel, i_limite, i_memoria_dado,
    input  o_memoria_endereco, o_leds, o_arduino_out, o_ativo, o_pronto
  );
  modport slave (
    input  i_iniciar, i_abortar, i_nivel, i_limite, i_memoria_dado,
    output o_memoria_endereco, o_leds, o_arduino_out, o_ativo, o_pronto
  );
`endif

endinterface

// File: rtl/sequenciador_reproducao_codificador.sv
// One-hot note to 3-bit buzzer code; anything not one-hot is a rest (valida=0).
module codificador_nota
  import sinfonia_pkg::*;
(
  input  logic [NOTA_W-1:0]    i_nota,
  output logic [ARDUINO_W-1:0] o_codigo,
  output logic                 o_valida
);

  always_comb begin
    o_codigo = SILENCIO;
    o_valida = (i_nota != '0) && ((i_nota & (i_nota - NOTA_W'(1))) == '0);
    for (int k = 0; k < int'(NOTA_W); k++) begin
      if (i_nota == (NOTA_W'(1) << k)) begin
        o_codigo = ARDUINO_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/sequenciador_reproducao.sv
// Plays notes at addresses 0..limite, each followed by a silent gap, then pulses pronto.
// Optional SEQ_REPETE_EN adds a repetir input that loops playback instead of finishing.
module sequenciador_reproducao
  import sinfonia_pkg::*;
#(
  parameter int unsigned NOTA_CICLOS_FACIL   = 50_000_000,
  parameter int unsigned NOTA_CICLOS_DIFICIL = 25_000_000,
  parameter int unsigned PAUSA_CICLOS        = 10_000_000,
  parameter int unsigned ADDR_W              = 4
) (
  input logic                      i_clock,
  input logic                      i_reset,
  sequenciador_reproducao_if.slave bus
);

  localparam int unsigned MaxCiclos =
      max_u(max_u(NOTA_CICLOS_FACIL, NOTA_CICLOS_DIFICIL), PAUSA_CICLOS);
  localparam int unsigned TimerW = $clog2(MaxCiclos + 1);

  localparam logic [TimerW-1:0] CicFacil   = TimerW'(NOTA_CICLOS_FACIL);
  localparam logic [TimerW-1:0] CicDificil = TimerW'(NOTA_CICLOS_DIFICIL);
  localparam logic [TimerW-1:0] CicPausa   = TimerW'(PAUSA_CICLOS);
  localparam logic [TimerW-1:0] TimerUm    = TimerW'(1);

  estado_e           r_estado;
  logic [TimerW-1:0] r_timer;
  logic [ADDR_W-1:0] r_endereco;
  logic [ADDR_W-1:0] r_limite;
  logic              r_nivel;
  logic              r_ativo;
  logic              r_pronto;
  logic              r_primeiro;
  logic [NOTA_W-1:0] r_nota;

  logic [NOTA_W-1:0]    w_nota;
  logic [ARDUINO_W-1:0] w_codigo;
  logic                 w_valida;
  logic                 w_tocando;

  always_ff @(posedge i_clock) begin
    if (i_reset || bus.i_abortar) begin
      r_estado   <= OCIOSO;
      r_timer    <= '0;
      r_endereco <= '0;
      r_limite   <= '0;
      r_nivel    <= 1'b0;
      r_ativo    <= 1'b0;
      r_pronto   <= 1'b0;
      r_primeiro <= 1'b0;
      r_nota     <= '0;
    end else begin
      unique case (r_estado)
        OCIOSO: begin
          if (bus.i_iniciar) begin
            r_nivel    <= bus.i_nivel;
            r_limite   <= bus.i_limite;
            r_endereco <= '0;
            r_ativo    <= 1'b1;
            r_estado   <= LE_MEMORIA;
          end
        end
        LE_MEMORIA: begin
          r_timer    <= r_nivel ? CicDificil : CicFacil;
          r_primeiro <= 1'b1;
          r_estado   <= TOCA;
        end
        TOCA: begin
          r_primeiro <= 1'b0;
          if (r_primeiro) r_nota <= bus.i_memoria_dado;
          if (r_timer == TimerUm) begin
            r_timer  <= CicPausa;
            r_estado <= PAUSA;
          end else begin
            r_timer <= r_timer - TimerUm;
          end
        end
        PAUSA: begin
          if (r_timer == TimerUm) begin
            r_timer <= '0;
            if (r_endereco == r_limite) begin
`ifdef SEQ_REPETE_EN
              // Looping skips FIM so the repeat period is exactly one pass long.
              if (bus.i_repetir) begin
                r_endereco <= '0;
                r_estado   <= LE_MEMORIA;
              end else begin
                r_ativo  <= 1'b0;
                r_pronto <= 1'b1;
                r_estado <= FIM;
              end
`else
              r_ativo  <= 1'b0;
              r_pronto <= 1'b1;
              r_estado <= FIM;
`endif
            end else begin
              r_endereco <= r_endereco + ADDR_W'(1);
              r_estado   <= LE_MEMORIA;
            end
          end else begin
            r_timer <= r_timer - TimerUm;
          end
        end
        FIM: begin
          r_pronto <= 1'b0;
          r_estado <= OCIOSO;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  // Read data only arrives in the first TOCA cycle, so bypass the note register there.
  assign w_nota    = r_primeiro ? bus.i_memoria_dado : r_nota;
  assign w_tocando = (r_estado == TOCA);

  codificador_nota u_codificador (
    .i_nota   (w_nota),
    .o_codigo (w_codigo),
    .o_valida (w_valida)
  );

  assign bus.o_leds             = (w_tocando && w_valida) ? w_nota : '0;
  assign bus.o_arduino_out      = (w_tocando && w_valida) ? w_codigo : SILENCIO;
  assign bus.o_memoria_endereco = r_endereco;
  assign bus.o_ativo            = r_ativo;
  assign bus.o_pronto           = r_pronto;

endmodule

// File: tb/tb_sequenciador_reproducao.sv
// Scoreboard bench: a cycle-offset reference model fills a queue, a monitor compares each cycle.
module tb_sequenciador_reproducao;
  import sinfonia_pkg::*;

  localparam int unsigned NF = 4;
  localparam int unsigned ND = 2;
  localparam int unsigned PC = 2;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sequenciador_reproducao_if #(.ADDR_W(AW)) u_if ();

  sequenciador_reproducao #(
    .NOTA_CICLOS_FACIL   (NF),
    .NOTA_CICLOS_DIFICIL (ND),
    .PAUSA_CICLOS        (PC),
    .ADDR_W              (AW)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (u_if)
  );

  logic [6:0] mem [16];

  // Synchronous-read note memory: data valid one cycle after the address.
  always_ff @(posedge clk) u_if.i_memoria_dado <= mem[u_if.o_memoria_endereco];

  typedef struct {
    logic [6:0] leds;
    logic [2:0] ard;
    logic       ativo;
    logic       pronto;
    logic [3:0] addr;
    bit         chk_addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [2:0] ref_code(input logic [6:0] n);
    if ($countones(n) != 1) return 3'd0;
    for (int k = 0; k < 7; k++) if (n[k]) return 3'(k + 1);
    return 3'd0;
  endfunction

  function automatic logic [6:0] rand_note();
    int r;
    logic [6:0] two;
    r = int'($urandom_range(0, 9));
    two = 7'b0000011;
    if (r < 7) return 7'(1) << r;
    if (r == 7) return 7'd0;
    return two << $urandom_range(0, 5);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (u_if.o_leds !== e.leds || u_if.o_arduino_out !== e.ard ||
          u_if.o_ativo !== e.ativo || u_if.o_pronto !== e.pronto ||
          (e.chk_addr && u_if.o_memoria_endereco !== e.addr)) begin
        n_err++;
        $display("FAIL cycle t=%0t: got leds=%b ard=%0d ativo=%b pronto=%b addr=%0d, want leds=%b ard=%0d ativo=%b pronto=%b addr=%0d(chk=%0d)",
                 $time, u_if.o_leds, u_if.o_arduino_out, u_if.o_ativo, u_if.o_pronto,
                 u_if.o_memoria_endereco, e.leds, e.ard, e.ativo, e.pronto, e.addr, e.chk_addr);
      end
    end
  end

  // Expected outputs per cycle offset k from the iniciar cycle, built from slot arithmetic.
  task automatic push_trace(input int nivel, input int lim, input int passes, input int cut,
                            output int len);
    int n, s, q, fim, last;
    n = (nivel != 0) ? int'(ND) : int'(NF);
    s = 1 + n + int'(PC);
    q = (lim + 1) * s;
    fim = 1 + passes * q;
    last = (cut >= 0) ? cut + 3 : fim + 1;
    for (int k = 0; k <= last; k++) begin
      exp_t e;
      e.leds = '0; e.ard = '0; e.ativo = 1'b0; e.pronto = 1'b0; e.addr = '0; e.chk_addr = 1'b0;
      if (cut >= 0 && k > cut) begin
        e.chk_addr = 1'b1;
      end else if (k >= 1 && k < fim) begin
        int pos, j;
        pos = (k - 1) % s;
        j = ((k - 1) / s) % (lim + 1);
        e.ativo = 1'b1;
        e.addr = 4'(j);
        e.chk_addr = 1'b1;
        if (pos >= 1 && pos <= n) begin
          e.ard = ref_code(mem[j]);
          e.leds = (e.ard != 3'd0) ? mem[j] : 7'd0;
        end
      end else if (k == fim) begin
        e.pronto = 1'b1;
        e.addr = 4'(lim);
        e.chk_addr = 1'b1;
      end
      exp_q.push_back(e);
    end
    len = last + 1;
  endtask

  // Called just after a rising edge; drives one cycle of stimulus per trace entry.
  task automatic run(input int nivel, input int lim, input int passes, input int cut,
                     input bit cut_rst, input int extra);
    int len, q;
    q = (lim + 1) * (1 + ((nivel != 0) ? int'(ND) : int'(NF)) + int'(PC));
    push_trace(nivel, lim, passes, cut, len);
    for (int k = 0; k < len; k++) begin
      u_if.i_iniciar = (k == 0) || (k == extra);
      u_if.i_nivel   = (k == 0) ? 1'(nivel) : 1'($urandom_range(0, 1));
      u_if.i_limite  = (k == 0) ? 4'(lim) : 4'($urandom_range(0, 15));
      u_if.i_abortar = (cut >= 0) && !cut_rst && (k == cut);
      rst            = (cut >= 0) && cut_rst && (k == cut);
`ifdef SEQ_REPETE_EN
      u_if.i_repetir = (passes > 1) && (k <= (passes - 1) * q);
`endif
      @(posedge clk);
      #1;
    end
    u_if.i_iniciar = 1'b0;
    u_if.i_abortar = 1'b0;
    rst = 1'b0;
`ifdef SEQ_REPETE_EN
    u_if.i_repetir = 1'b0;
`endif
  endtask

  initial begin
    int lim, niv, fim, cut, extra;
    bit crst;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    u_if.i_iniciar = 1'b0;
    u_if.i_abortar = 1'b0;
    u_if.i_nivel   = 1'b0;
    u_if.i_limite  = '0;
`ifdef SEQ_REPETE_EN
    u_if.i_repetir = 1'b0;
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.leds = '0; e.ard = '0; e.ativo = 1'b0; e.pronto = 1'b0; e.addr = '0; e.chk_addr = 1'b1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    mem[0] = 7'b0000001; mem[1] = 7'b0000100; mem[2] = 7'b1000000;
    run(0, 2, 1, -1, 1'b0, -1);          // slow notes, pronto at +22
    run(1, 2, 1, -1, 1'b0, -1);          // fast notes, pronto at +16
    mem[1] = 7'b0000110;
    run(0, 2, 1, -1, 1'b0, -1);          // non-one-hot slot is a rest
    mem[1] = 7'b0000100;
    run(0, 2, 1, 10, 1'b0, -1);          // abort during second note
    run(0, 2, 1, 10, 1'b1, 5);           // stray iniciar, then reset mid-note
    mem[0] = rand_note();
    run(1, 0, 1, -1, 1'b0, -1);          // single note
    for (int i = 0; i < 16; i++) mem[i] = rand_note();
    run(0, 15, 1, -1, 1'b0, -1);         // full memory, no address wrap

    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = rand_note();
      niv = int'($urandom_range(0, 1));
      lim = int'($urandom_range(0, 15));
      fim = 1 + (lim + 1) * (1 + ((niv != 0) ? int'(ND) : int'(NF)) + int'(PC));
      cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, fim - 1)) : -1;
      crst = 1'($urandom_range(0, 1));
      extra = -1;
      if ($urandom_range(0, 1) == 1) begin
        extra = int'($urandom_range(1, (cut >= 0) ? cut : fim - 1));
      end
      run(niv, lim, 1, cut, crst, extra);
    end

`ifdef SEQ_REPETE_EN
    mem[0] = 7'b0010000;
    run(0, 0, 3, -1, 1'b0, -1);          // three 7-cycle passes, one pronto
    mem[0] = rand_note(); mem[1] = rand_note();
    run(1, 1, 2, -1, 1'b0, -1);
`endif

    @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
